// File: rtl/usb_tx_pkg.sv
// Shared types and default sizing for the USB transmit scheduler.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    KICK  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } sched_state_t;

  // Packet length limit matches the transmitter FIFO depth.
  localparam int unsigned MAX_LEN_DEF    = 8;
  // Idle clocks after the FIFO empties: last byte serialization plus EOP.
  localparam int unsigned GAP_CYCLES_DEF = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with a last-served register that only moves
// when the scheduler actually commits the grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic r_last_served;

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last_served ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Record the winner; reset value 1 lets requester 0 take the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_served <= 1'b1;
    end else if (i_accept && (o_gnt != 2'b00)) begin
      r_last_served <= o_gnt[1];
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Two-requester packet scheduler: loads one granted packet into the
// transmitter FIFO, kicks the transmitter, then waits for drain plus an
// inter-packet gap before the next grant.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  grant,
  output logic        write_enable,
  output logic [7:0]  write_data,
  output logic        transmit,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        busy,
  output logic        len_err
);

  localparam int unsigned    GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0]     MAX_CNT  = 8'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  sched_state_t     r_state, w_state_nxt;
  logic [1:0]       r_grant, w_grant_nxt;
  logic [7:0]       r_count, w_count_nxt, w_count_inc;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic             r_len_err, w_len_err_nxt;
  logic             r_drain_first, w_drain_first_nxt;
  logic [1:0]       w_arb_gnt;
  logic             w_arb_accept;
  logic             w_xfer;
  logic             w_last;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req_valid),
    .i_accept (w_arb_accept),
    .o_gnt    (w_arb_gnt)
  );

  // Zero-latency handshake and byte mux from the granted requester into the FIFO.
  always_comb begin
    req_ready    = ((r_state == LOAD) && !fifo_full) ? r_grant : 2'b00;
    w_xfer       = |(req_ready & req_valid);
    w_last       = r_grant[1] ? req_last[1] : req_last[0];
    write_enable = w_xfer;
    write_data   = r_grant[1] ? req_data[15:8] : req_data[7:0];
    w_count_inc  = r_count + 8'd1;
  end

  // Next-state logic; every register holds unless a state says otherwise.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_count_nxt       = r_count;
    w_gap_nxt         = r_gap_cnt;
    w_len_err_nxt     = r_len_err;
    w_drain_first_nxt = r_drain_first;
    w_arb_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_gnt != 2'b00) begin
          w_arb_accept = 1'b1;
          w_grant_nxt  = w_arb_gnt;
          w_count_nxt  = 8'd0;
          w_state_nxt  = LOAD;
        end
      end
      LOAD: begin
        if (w_xfer) begin
          w_count_nxt = w_count_inc;
          if (w_last) begin
            w_state_nxt = KICK;
          end else if (w_count_inc == MAX_CNT) begin
            // Force-split: the rest of this stream becomes its next packet.
            w_state_nxt   = KICK;
            w_len_err_nxt = 1'b1;
          end
        end
      end
      KICK: begin
        w_state_nxt       = DRAIN;
        w_drain_first_nxt = 1'b1;
      end
      DRAIN: begin
        // The transmitter may not have popped yet on the first DRAIN cycle.
        w_drain_first_nxt = 1'b0;
        if (!r_drain_first && fifo_empty) begin
          w_gap_nxt   = GAP_LOAD;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
          w_grant_nxt = 2'b00;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  // State and counter registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= 2'b00;
      r_count       <= 8'd0;
      r_gap_cnt     <= '0;
      r_len_err     <= 1'b0;
      r_drain_first <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_count       <= w_count_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_len_err     <= w_len_err_nxt;
      r_drain_first <= w_drain_first_nxt;
    end
  end

  assign grant    = r_grant;
  assign transmit = (r_state == KICK);
  assign busy     = (r_state != IDLE);
  assign len_err  = r_len_err;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Self-checking bench for usb_tx_scheduler: directed table, hand sequences
// for timing corners, and randomized packets against a transaction model.
module tb_usb_tx_scheduler;

  localparam int MAXL = 8;
  localparam int GAPC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic        write_enable, transmit, fifo_empty, fifo_full, busy, len_err;
  logic [7:0]  write_data;

  usb_tx_scheduler #(.MAX_LEN(MAXL), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .write_enable(write_enable), .write_data(write_data), .transmit(transmit),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [8:0] q0[$], q1[$];       // source streams {last, byte}
  logic [8:0] m0[$], m1[$];       // model copies of the same streams
  logic [9:0] ev[$], exp_ev[$];   // {is_transmit, requester, byte}
  int         ev_cyc[$];
  logic [1:0] g_hist[$];
  logic [1:0] vmask, prev_grant;
  logic       auto_fifo, fe_man, ff_man, ff_rand, exp_err;
  int         level, draining, stall_at, stall_left, n_wr, n_tx, inv_err, cyc;
  logic       s_we, s_tx, s_busy, s_lerr;
  logic [7:0] s_wd;
  logic [1:0] s_grant, s_ready;
  logic [7:0] t1b[3];

  typedef struct {
    int len0; int len1; int st_at; int st_len;
    int exp_wr; int exp_tx; int exp_err;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // One clock: drive inputs after the falling edge, sample 1 time unit later.
  task automatic tick();
    logic ff_now;
    @(negedge clk);
    req_valid[0] = (q0.size() != 0) && vmask[0];
    req_valid[1] = (q1.size() != 0) && vmask[1];
    req_data = 16'h0000;
    req_last = 2'b00;
    if (q0.size() != 0) begin req_data[7:0]  = q0[0][7:0]; req_last[0] = q0[0][8]; end
    if (q1.size() != 0) begin req_data[15:8] = q1[0][7:0]; req_last[1] = q1[0][8]; end
    ff_now = ff_man;
    if (stall_left > 0 && n_wr == stall_at) begin ff_now = 1'b1; stall_left--; end
    if (ff_rand && $urandom_range(0, 3) == 0) ff_now = 1'b1;
    fifo_full  = ff_now;
    fifo_empty = auto_fifo ? (level == 0) : fe_man;
    #1;
    s_we = write_enable; s_wd = write_data; s_tx = transmit; s_busy = busy;
    s_lerr = len_err; s_grant = grant; s_ready = req_ready;
    if ((req_ready & ~grant) != 2'b00) inv_err++;
    if (fifo_full && (req_ready != 2'b00 || write_enable)) inv_err++;
    if (write_enable !== (|(req_ready & req_valid))) inv_err++;
    if (grant != prev_grant) begin g_hist.push_back(grant); prev_grant = grant; end
    if (write_enable) begin
      ev.push_back({1'b0, grant[1], write_data}); ev_cyc.push_back(cyc);
      n_wr++; level++;
    end
    if (transmit) begin
      ev.push_back(10'h200); ev_cyc.push_back(cyc); n_tx++; draining = 1;
    end else if (draining != 0 && level > 0 && (!ff_rand || $urandom_range(0, 1) == 1)) begin
      level--;
    end
    if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
    if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
    cyc++;
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete(); m0.delete(); m1.delete();
    ev.delete(); ev_cyc.delete(); exp_ev.delete(); g_hist.delete();
    vmask = 2'b11; auto_fifo = 1'b1; fe_man = 1'b0; ff_man = 1'b0; ff_rand = 1'b0;
    level = 0; draining = 0; stall_at = -1; stall_left = 0; n_wr = 0; n_tx = 0;
    prev_grant = 2'b00; exp_err = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    if (r == 0) begin q0.push_back({last, d}); m0.push_back({last, d}); end
    else begin q1.push_back({last, d}); m1.push_back({last, d}); end
  endtask

  task automatic add_pkt(input int r, input int len, input int seed, input bit rnd);
    for (int k = 0; k < len; k++)
      add_byte(r, rnd ? 8'($urandom) : 8'(seed + k), (k == len - 1));
  endtask

  // Transaction model: round-robin between non-empty streams, packets end at
  // a last flag or are cut at MAXL bytes; each packet is followed by a kick.
  task automatic run_model();
    int ls = 1;
    int g, cnt;
    logic gb, done;
    logic [8:0] b;
    while (m0.size() != 0 || m1.size() != 0) begin
      if (m0.size() != 0 && m1.size() != 0) g = (ls == 1) ? 0 : 1;
      else g = (m0.size() != 0) ? 0 : 1;
      ls = g; gb = (g == 1); cnt = 0; done = 1'b0;
      while (!done) begin
        if (g == 0) b = m0.pop_front();
        else b = m1.pop_front();
        cnt++;
        exp_ev.push_back({1'b0, gb, b[7:0]});
        if (b[8]) done = 1'b1;
        else if (cnt == MAXL) begin done = 1'b1; exp_err = 1'b1; end
      end
      exp_ev.push_back(10'h200);
    end
  endtask

  task automatic run_all(input string name, input int budget);
    int t;
    tick(); t = 1;
    while (t < budget && (q0.size() != 0 || q1.size() != 0 || s_busy)) begin tick(); t++; end
    if (t >= budget) chk({name, " timeout"}, 1, 0);
  endtask

  task automatic cmp_ev(input string name);
    int bad = 0;
    chk({name, " event count"}, ev.size(), exp_ev.size());
    for (int k = 0; k < ev.size() && k < exp_ev.size(); k++)
      if (ev[k] !== exp_ev[k]) bad++;
    chk({name, " event order"}, bad, 0);
    chk({name, " len_err"}, 32'(s_lerr), 32'(exp_err));
  endtask

  initial begin
    int n, w0, gap;
    logic busy_ok;
    logic [5:0] gs;
    rst = 1'b1;
    req_valid = 2'b00; req_data = 16'h0; req_last = 2'b00;
    fifo_empty = 1'b1; fifo_full = 1'b0; inv_err = 0; cyc = 0;
    t1b = '{8'hA5, 8'h3C, 8'hFF};
    tbl[0] = '{3, 0, -1, 0, 3, 1, 0};
    tbl[1] = '{2, 2, -1, 0, 4, 2, 0};
    tbl[2] = '{4, 0, 2, 3, 4, 1, 0};
    tbl[3] = '{10, 0, -1, 0, 10, 2, 1};
    tbl[4] = '{8, 0, -1, 0, 8, 1, 0};
    tbl[5] = '{9, 1, -1, 0, 10, 3, 1};
    tbl[6] = '{1, 1, -1, 0, 2, 2, 0};
    tbl[7] = '{0, 12, 5, 2, 12, 2, 1};

    // Single packet A5,3C,FF with exact cycle timing and gap length.
    do_reset();
    chk("reset grant", 32'(s_grant), 0);
    chk("reset busy", 32'(s_busy), 0);
    chk("reset len_err", 32'(s_lerr), 0);
    chk("reset transmit", 32'(s_tx), 0);
    chk("reset req_ready", 32'(s_ready), 0);
    auto_fifo = 1'b0;
    add_byte(0, 8'hA5, 1'b0); add_byte(0, 8'h3C, 1'b0); add_byte(0, 8'hFF, 1'b1);
    tick();
    chk("t1 idle no write", 32'(s_we), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1 write_enable", 32'(s_we), 1);
      chk("t1 write_data", 32'(s_wd), 32'(t1b[k]));
      chk("t1 grant", 32'(s_grant), 1);
    end
    tick();
    chk("t1 transmit", 32'(s_tx), 1);
    chk("t1 no write in kick", 32'(s_we), 0);
    repeat (4) tick();
    chk("t1 single transmit", n_tx, 1);
    chk("t1 busy in drain", 32'(s_busy), 1);
    fe_man = 1'b1;
    tick();
    n = 0;
    while (s_busy && n < 100) begin tick(); n++; end
    chk("t1 busy drop", n, GAPC + 1);

    // Both requesters from the same cycle: order, grant sequence, full gap.
    do_reset();
    add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h22, 1'b1);
    add_byte(1, 8'h33, 1'b0); add_byte(1, 8'h44, 1'b1);
    run_model();
    run_all("t2", 500);
    cmp_ev("t2");
    gs = 6'h3f;
    if (g_hist.size() >= 3) gs = {g_hist[0], g_hist[1], g_hist[2]};
    chk("t2 grant sequence", 32'(gs), 32'(6'b01_00_10));
    gap = 0;
    if (ev_cyc.size() >= 4) gap = ev_cyc[3] - ev_cyc[2];
    chk("t2 drain+gap before second packet", 32'(gap >= GAPC + 4), 1);

    // Directed table of lengths, stalls and force-splits.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      add_pkt(0, tbl[i].len0, 16 * i, 1'b0);
      add_pkt(1, tbl[i].len1, 16 * i + 128, 1'b0);
      stall_at = tbl[i].st_at; stall_left = tbl[i].st_len;
      run_model();
      run_all($sformatf("vec%0d", i), 1000);
      chk($sformatf("vec%0d writes", i), n_wr, tbl[i].exp_wr);
      chk($sformatf("vec%0d transmits", i), n_tx, tbl[i].exp_tx);
      chk($sformatf("vec%0d table len_err", i), 32'(s_lerr), tbl[i].exp_err);
      cmp_ev($sformatf("vec%0d", i));
    end

    // Reset during LOAD after two bytes.
    do_reset();
    for (int k = 0; k < 4; k++) add_byte(0, 8'(8'h50 + k), (k == 3));
    n = 0;
    while (n_wr < 2 && n < 50) begin tick(); n++; end
    chk("t5 two bytes loaded", n_wr, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5 rst grant", 32'(grant), 0);
    chk("t5 rst busy", 32'(busy), 0);
    chk("t5 rst req_ready", 32'(req_ready), 0);
    chk("t5 rst write_enable", 32'(write_enable), 0);
    chk("t5 rst transmit", 32'(transmit), 0);
    q0.delete(); m0.delete();
    tick(); tick();
    add_byte(1, 8'h77, 1'b1); add_byte(0, 8'h66, 1'b1);
    rst = 1'b0;
    n = 0;
    while (s_grant == 2'b00 && n < 20) begin tick(); n++; end
    chk("t5 first grant after reset", 32'(s_grant), 1);
    chk("t5 no transmit", n_tx, 0);

    // req_valid gap of 5 cycles mid-packet.
    do_reset();
    for (int k = 0; k < 6; k++) add_byte(0, 8'(8'h90 + k), (k == 5));
    run_model();
    n = 0;
    while (n_wr < 2 && n < 50) begin tick(); n++; end
    vmask = 2'b10; w0 = n_wr; busy_ok = 1'b1;
    repeat (5) begin tick(); if (!s_busy) busy_ok = 1'b0; end
    chk("t6 no writes in valid gap", n_wr - w0, 0);
    chk("t6 held in load", 32'(busy_ok), 1);
    vmask = 2'b11;
    run_all("t6", 500);
    chk("t6 total writes", n_wr, 6);
    cmp_ev("t6");

    // Randomized streams, stalls and drain pacing against the model.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      ff_rand = 1'b1;
      for (int r = 0; r < 2; r++)
        repeat ($urandom_range(0, 3)) add_pkt(r, $urandom_range(1, 12), 0, 1'b1);
      run_model();
      run_all($sformatf("rand%0d", it), 3000);
      cmp_ev($sformatf("rand%0d", it));
    end

    chk("handshake invariants", inv_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Two-requester packet scheduler in front of the USB transmitter datapath (byte FIFO plus serializer, driving d_plus/d_minus).
- Arbitrates round-robin between two byte-stream sources.
- Loads one granted packet at a time into the transmitter FIFO through write_enable/write_data, then pulses transmit.
- Holds off the next grant until the FIFO has drained and an inter-packet gap has elapsed.

Parameters:
- MAX_LEN, 8: maximum bytes per packet, equal to the transmitter FIFO depth; range 1..255.
- GAP_CYCLES, 16: idle clocks after fifo_empty rises before the next grant; covers the last byte's serialization and EOP; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents a byte on req_data.
- req_data  in  16  byte for requester i is req_data[8*i+7 : 8*i].
- req_last  in  2  bit i: the current byte is the last of requester i's packet.
- req_ready  out  2  bit i: the current byte of requester i is accepted this cycle.
- grant  out  2  one-hot owner of the transmitter; 00 when idle.
- write_enable  out  1  transmitter FIFO write strobe.
- write_data  out  8  transmitter FIFO write byte.
- transmit  out  1  one-cycle start pulse to the transmitter.
- fifo_empty  in  1  transmitter FIFO empty.
- fifo_full  in  1  transmitter FIFO full.
- busy  out  1  high in every state except IDLE.
- len_err  out  1  sticky; set when a packet is force-split at MAX_LEN.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, grant=00, transmit=0, len_err=0, byte count=0, last_served=1 so requester 0 wins the first tie.
  - All combinational outputs (req_ready, write_enable) are 0 in IDLE.
  - Asserting rst mid-packet abandons the packet immediately. No transmit pulse is issued.
- Transfer:
  - A byte transfers on requester g when req_valid[g] && req_ready[g].
  - req_ready[g] = (state==LOAD) && grant[g] && !fifo_full. This is combinational, and the non-granted requester's bit is always 0.
  - write_enable = transfer, and write_data = the granted requester's byte. Both are combinational, so there is zero-cycle latency into the FIFO.
- IDLE:
  - With neither req_valid bit set, stay in IDLE.
  - With exactly one bit set, grant that requester.
  - With both set, grant the requester that is not last_served.
  - Register grant, update last_served, clear count, then go to LOAD.
- LOAD:
  - Each transfer increments count.
  - On a transfer with req_last[g]=1, go to KICK.
  - On a transfer that makes count==MAX_LEN with req_last[g]=0, go to KICK and set len_err. That requester's remaining bytes form its next packet.
  - While fifo_full=1 there is no transfer and the state is held. A req_valid gap is also simply held; there is no timeout.
- KICK: transmit=1 for exactly this one cycle, then go to DRAIN.
- DRAIN:
  - Wait until fifo_empty=1.
  - fifo_empty is ignored in the first DRAIN cycle, because the transmitter may not have popped yet.
  - Then load gap_cnt=GAP_CYCLES-1 and go to GAP.
- GAP:
  - Decrement gap_cnt each cycle.
  - At gap_cnt==0, go to IDLE and clear grant.
  - busy stays high throughout GAP.
- Throughput and timing:
  - Minimum cycles from an IDLE grant to transmit is N+1 for an N-byte packet with no stalls.
  - A requester that is still valid in IDLE after its own packet yields to the other requester if that one is valid; otherwise it is re-granted.
- Counters:
  - count is 8 bits and never exceeds MAX_LEN.
  - gap_cnt is $clog2(GAP_CYCLES) bits, minimum 1.
- len_err clears only on rst.

Decomposition:
- Shared package usb_tx_pkg:
  - typedef enum logic [2:0] {IDLE, LOAD, KICK, DRAIN, GAP} sched_state_t.
  - Default constants for MAX_LEN and GAP_CYCLES.
- One sub-module, rr_arbiter2: a 2-way round-robin grant with a last_served register and an update-on-accept input. The FSM, counters and muxing stay in usb_tx_scheduler.

Test Plan:
- Single packet, bytes A5,3C,FF from req 0 only:
  - grant=01; write_enable is high for 3 consecutive cycles carrying A5,3C,FF.
  - transmit pulses for 1 cycle on the following cycle.
  - After fifo_empty is forced high, busy drops exactly GAP_CYCLES+1 cycles later.
- Both requesters valid from the same cycle after reset, each with a 2-byte packet (11,22 / 33,44):
  - The writes appear in order 11,22, then 33,44 after a full DRAIN+GAP.
  - grant sequence is 01, 00, 10.
- fifo_full held high for 3 cycles in the middle of a 4-byte packet:
  - req_ready and write_enable stay low during the stall; no byte is lost or duplicated.
  - transmit follows the 4th write.
- Packet of MAX_LEN+2 = 10 bytes with last only on byte 10:
  - 8 writes, then transmit, then len_err=1.
  - After the gap, req 0 is re-granted (req 1 idle) for 2 bytes, followed by a second transmit pulse.
- rst pulsed high during LOAD after 2 bytes:
  - Outputs return to their reset values within the same cycle.
  - No transmit pulse occurs, and the next grant after release goes to req 0.
- req_valid dropped for 5 cycles mid-packet:
  - The scheduler holds LOAD with no writes, then resumes.
  - The total write count equals the packet length.
